// File: rtl/la_iopwrseq.sv
// Power-on / retention sequencer driving the io ring control lanes.
// Debounces synchronized power-goods, orders iso/ret/ioen release and handles retention.
module la_iopwrseq #(
  parameter int unsigned RINGW    = 8,
  parameter int unsigned SYNC     = 2,
  parameter int unsigned DEBOUNCE = 16,
  parameter int unsigned STEP     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pg_vdd,
  input  logic             pg_vddio,
  input  logic             sleep_req,
  input  logic             wake_req,
  output logic [RINGW-1:0] ring_ctrl,
  output logic [2:0]       state,
  output logic             ready,
  output logic             pg_fault
);

  localparam int unsigned MAXC = (DEBOUNCE > STEP) ? DEBOUNCE : STEP;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_ENABLE    = 3'd1,
    S_ON        = 3'd2,
    S_RET_ENTRY = 3'd3,
    S_SLEEP     = 3'd4,
    S_RET_EXIT  = 3'd5
  } state_t;

  state_t          cur;
  state_t          nxt;
  logic [SYNC-1:0] sync_vdd;
  logic [SYNC-1:0] sync_vddio;
  logic            pg_ok;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            fault_nxt;
  logic            dwell_done;
  logic            deb_done;

  // Lane word {ioen, ret, iso} for a given state.
  function automatic logic [2:0] ctrl_of(input state_t s);
    logic [2:0] c;
    c = 3'b001;
    case (s)
      S_OFF:       c = 3'b001;
      S_ENABLE:    c = 3'b101;
      S_ON:        c = 3'b100;
      S_RET_ENTRY: c = 3'b101;
      S_SLEEP:     c = 3'b011;
      S_RET_EXIT:  c = 3'b101;
      default:     c = 3'b001;
    endcase
    return c;
  endfunction

  // Power-good synchronizers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_vdd   <= '0;
      sync_vddio <= '0;
    end else begin
      sync_vdd   <= {sync_vdd[SYNC-2:0], pg_vdd};
      sync_vddio <= {sync_vddio[SYNC-2:0], pg_vddio};
    end
  end

  assign pg_ok      = sync_vdd[SYNC-1] & sync_vddio[SYNC-1];
  assign dwell_done = (cnt == CW'(STEP - 1));
  assign deb_done   = (cnt == CW'(DEBOUNCE - 1));

  // State register and shared counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= S_OFF;
      cnt <= '0;
    end else begin
      cur <= nxt;
      cnt <= cnt_nxt;
    end
  end

  // Next state; power-good loss overrides every other transition.
  always_comb begin
    nxt       = cur;
    fault_nxt = 1'b0;
    cnt_nxt   = '0;
    case (cur)
      S_OFF:       if (pg_ok && deb_done) nxt = S_ENABLE;
      S_ENABLE:    if (dwell_done) nxt = S_ON;
      S_ON:        if (sleep_req) nxt = S_RET_ENTRY;
      S_RET_ENTRY: if (dwell_done) nxt = S_SLEEP;
      S_SLEEP:     if (wake_req) nxt = S_RET_EXIT;
      S_RET_EXIT:  if (dwell_done) nxt = S_ON;
      default:     nxt = S_OFF;
    endcase
    if (cur != S_OFF && !pg_ok) begin
      nxt       = S_OFF;
      fault_nxt = 1'b1;
    end
    if (nxt == cur) begin
      case (cur)
        S_OFF:                              cnt_nxt = pg_ok ? cnt + CW'(1) : '0;
        S_ENABLE, S_RET_ENTRY, S_RET_EXIT:  cnt_nxt = cnt + CW'(1);
        default:                            cnt_nxt = '0;
      endcase
    end
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      ring_ctrl <= RINGW'(3'b001);
      ready     <= 1'b0;
      pg_fault  <= 1'b0;
    end else begin
      ring_ctrl <= RINGW'(ctrl_of(nxt));
      ready     <= (nxt == S_ON);
      pg_fault  <= fault_nxt;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_la_iopwrseq.sv
// Scoreboard bench for la_iopwrseq: timestamp-based reference model, directed plan plus random traffic.
module tb_la_iopwrseq;

  localparam int RINGW    = 8;
  localparam int SYNC     = 2;
  localparam int DEBOUNCE = 16;
  localparam int STEP     = 4;

  logic             clk;
  logic             rst;
  logic             pg_vdd;
  logic             pg_vddio;
  logic             sleep_req;
  logic             wake_req;
  logic [RINGW-1:0] ring_ctrl;
  logic [2:0]       state;
  logic             ready;
  logic             pg_fault;

  la_iopwrseq #(.RINGW(RINGW), .SYNC(SYNC), .DEBOUNCE(DEBOUNCE), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .pg_vdd(pg_vdd), .pg_vddio(pg_vddio),
    .sleep_req(sleep_req), .wake_req(wake_req),
    .ring_ctrl(ring_ctrl), .state(state), .ready(ready), .pg_fault(pg_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st;
    int ring;
    bit rdy;
    bit flt;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: timestamps of state entry and of the current power-good run.
  bit dly_v[$];
  bit dly_io[$];
  int edge_n    = 0;
  int m_st      = 0;
  int m_entered = 0;
  int m_ok_since = -1;

  function automatic int ring_of(input int s);
    case (s)
      0: return 'h01;
      1: return 'h05;
      2: return 'h04;
      3: return 'h05;
      4: return 'h03;
      5: return 'h05;
      default: return 'h01;
    endcase
  endfunction

  task automatic clear_dly();
    dly_v  = {};
    dly_io = {};
    for (int i = 0; i < SYNC; i++) begin
      dly_v.push_back(1'b0);
      dly_io.push_back(1'b0);
    end
  endtask

  task automatic model_edge(input bit r, input bit v, input bit io, input bit s, input bit w);
    bit   ok;
    int   nst;
    bit   flt;
    exp_t e;
    edge_n++;
    ok = dly_v[0] && dly_io[0];
    void'(dly_v.pop_front());
    void'(dly_io.pop_front());
    dly_v.push_back(v);
    dly_io.push_back(io);
    nst = m_st;
    flt = 1'b0;
    if (r) begin
      clear_dly();
      nst = 0;
    end else if (m_st != 0 && !ok) begin
      nst = 0;
      flt = 1'b1;
    end else begin
      case (m_st)
        0: begin
          if (ok) begin
            if (m_ok_since < 0) m_ok_since = edge_n;
            if (edge_n - m_ok_since + 1 >= DEBOUNCE) nst = 1;
          end else begin
            m_ok_since = -1;
          end
        end
        1: if (edge_n - m_entered == STEP) nst = 2;
        2: if (s) nst = 3;
        3: if (edge_n - m_entered == STEP) nst = 4;
        4: if (w) nst = 5;
        5: if (edge_n - m_entered == STEP) nst = 2;
        default: nst = 0;
      endcase
    end
    if (r || nst != m_st) begin
      m_entered  = edge_n;
      m_ok_since = -1;
    end
    m_st  = nst;
    e.st   = m_st;
    e.ring = ring_of(m_st);
    e.rdy  = (m_st == 2);
    e.flt  = flt;
    sb.push_back(e);
  endtask

  // One clock of stimulus; the model sees the same inputs the DUT samples.
  task automatic step(input bit r, input bit v, input bit io, input bit s, input bit w);
    rst       = r;
    pg_vdd    = v;
    pg_vddio  = io;
    sleep_req = s;
    wake_req  = w;
    @(posedge clk);
    model_edge(r, v, io, s, w);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every cycle's outputs against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if (state !== 3'(e.st) || ring_ctrl !== RINGW'(e.ring) ||
            ready !== e.rdy || pg_fault !== e.flt) begin
          fails++;
          $display("FAIL sb t=%0t state=%0d/%0d ring=%h/%h ready=%b/%b fault=%b/%b (got/exp)",
                   $time, state, e.st, ring_ctrl, e.ring[RINGW-1:0], ready, e.rdy, pg_fault, e.flt);
        end
      end
    end
  end

  initial begin
    bit v;
    bit io;
    clear_dly();
    rst = 1'b1; pg_vdd = 1'b0; pg_vddio = 1'b0; sleep_req = 1'b0; wake_req = 1'b0;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_state", int'(state), 0);
    chk("rst_ring", int'(ring_ctrl), 'h01);
    chk("rst_ready", int'(ready), 0);
    chk("rst_fault", int'(pg_fault), 0);

    // Power-up: power-goods high from cycle 0.
    for (int i = 0; i < 17; i++) step(0, 1, 1, 0, 0);
    chk("pu_state17", int'(state), 0);
    step(0, 1, 1, 0, 0);
    chk("pu_state18", int'(state), 1);
    chk("pu_ring18", int'(ring_ctrl), 'h05);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
    chk("pu_state21", int'(state), 1);
    step(0, 1, 1, 0, 0);
    chk("pu_state22", int'(state), 2);
    chk("pu_ready22", int'(ready), 1);
    chk("pu_ring22", int'(ring_ctrl), 'h04);

    // Retention round trip.
    step(0, 1, 1, 1, 0);
    chk("ret_entry_ring", int'(ring_ctrl), 'h05);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
    chk("ret_entry_last", int'(ring_ctrl), 'h05);
    step(0, 1, 1, 0, 0);
    chk("sleep_ring", int'(ring_ctrl), 'h03);
    step(0, 1, 1, 1, 0);
    chk("sleep_ignores_sleep", int'(state), 4);
    step(0, 1, 1, 0, 1);
    chk("ret_exit_ring", int'(ring_ctrl), 'h05);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("wake_ring", int'(ring_ctrl), 'h04);
    chk("wake_ready", int'(ready), 1);

    // Simultaneous requests.
    step(0, 1, 1, 1, 1);
    chk("both_on", int'(state), 3);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 1);
    step(0, 1, 1, 1, 1);
    chk("both_sleep", int'(state), 4);
    step(0, 1, 1, 1, 1);
    chk("both_in_sleep", int'(state), 5);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
    chk("back_on", int'(state), 2);

    // Power-good loss during retention entry.
    step(0, 1, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("fault_wait", int'(state), 3);
    step(0, 0, 1, 0, 0);
    chk("fault_state", int'(state), 0);
    chk("fault_ring", int'(ring_ctrl), 'h01);
    chk("fault_pulse", int'(pg_fault), 1);
    step(0, 0, 1, 0, 0);
    chk("fault_once", int'(pg_fault), 0);

    // Debounce glitch: io power-good low for one input cycle.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 28; i++) step(0, 1, (i == 10) ? 1'b0 : 1'b1, 0, 0);
    chk("glitch_state28", int'(state), 0);
    step(0, 1, 1, 0, 0);
    chk("glitch_state29", int'(state), 1);

    // Reset during ENABLE.
    step(1, 1, 1, 0, 0);
    chk("midrst_state", int'(state), 0);
    chk("midrst_ring", int'(ring_ctrl), 'h01);
    chk("midrst_fault", int'(pg_fault), 0);

    // Random traffic against the model.
    v  = 1'b1;
    io = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      v  = v  ? ($urandom_range(0, 299) != 0) : ($urandom_range(0, 3) == 0);
      io = io ? ($urandom_range(0, 299) != 0) : ($urandom_range(0, 3) == 0);
      step(($urandom_range(0, 499) == 0), v, io,
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
    end

    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/la_iopwrseq.md
Name: la_iopwrseq

Overview:
- Synchronous power-on/retention sequencer that drives the control lanes of the generic io ring bus.
- Sits directly upstream of the io supply and pad cells; its ring_ctrl output is the word those cells receive on ioring.
- Debounces the core and io power-good indications, releases pad isolation in a fixed order, and sequences retention entry and exit on request.

Parameters:
- RINGW, 8, width of ring_ctrl; must be >= 4.
- SYNC, 2, synchronizer depth for the asynchronous power-good inputs; must be >= 2.
- DEBOUNCE, 16, consecutive cycles both synced power-goods must be high before power-up; must be >= 1.
- STEP, 4, dwell cycles in each transitional state; must be >= 1.

Ports:
- clk, input, 1, sequencer clock.
- rst, input, 1, synchronous active-high reset.
- pg_vdd, input, 1, asynchronous core-supply power-good.
- pg_vddio, input, 1, asynchronous io-supply power-good.
- sleep_req, input, 1, synchronous retention-entry request (level).
- wake_req, input, 1, synchronous retention-exit request (level).
- ring_ctrl, output, RINGW, io ring control word: [0]=iso, [1]=ret, [2]=ioen; [RINGW-1:3] are tied 0.
- state, output, 3, current state encoding.
- ready, output, 1, high only in ON.
- pg_fault, output, 1, one-cycle pulse on power-good loss from any non-OFF state.

Behaviour:
- Clocking and reset: single clock clk. rst is synchronous and active-high. All outputs are registered (Moore machine).
- Reset values: state=OFF(0), ring_ctrl={iso=1, ret=0, ioen=0}, ready=0, pg_fault=0. Counter and synchronizers are cleared to 0.
- Reset mid-operation returns to OFF on the next edge. No pg_fault pulse is generated on reset.
- Synchronization: pg_vdd and pg_vddio each pass through a SYNC-flop synchronizer. pg_ok = AND of the two synced values.
- Counter: one shared counter, width clog2(max(DEBOUNCE,STEP)+1). It clears on every state change.
- State encodings and outputs (iso/ret/ioen):
  - OFF=0: 1/0/0.
  - ENABLE=1: 1/0/1.
  - ON=2: 0/0/1.
  - RET_ENTRY=3: 1/0/1.
  - SLEEP=4: 1/1/0.
  - RET_EXIT=5: 1/0/1.
  - Encodings 6 and 7 are illegal and recover to OFF on the next cycle.
- OFF:
  - While pg_ok=1 the counter increments; a cycle with pg_ok=0 clears it.
  - When the counter reaches DEBOUNCE-1 with pg_ok=1, go to ENABLE.
  - If the first pg_ok=1 cycle is t, state=ENABLE at t+DEBOUNCE.
- ENABLE: dwell STEP cycles, then go to ON.
- ON:
  - sleep_req=1 goes to RET_ENTRY.
  - wake_req is ignored.
- RET_ENTRY: dwell STEP cycles, then go to SLEEP.
- SLEEP:
  - wake_req=1 goes to RET_EXIT.
  - sleep_req is ignored.
- RET_EXIT: dwell STEP cycles, then go to ON. ret drops on entry to RET_EXIT, before iso drops.
- Dwell rule: a state entered at cycle e exits at e+STEP.
- Ordering invariants:
  - iso is never 0 while ret=1 or ioen=0.
  - ret and ioen are never both 1.
  - Every ON<->SLEEP path passes through a state with iso=1, ioen=1, ret=0.
- Power-good loss:
  - pg_ok=0 in any state other than OFF goes to OFF on the next edge.
  - pg_fault pulses 1 in the same cycle OFF is entered.
  - This has priority over sleep_req, wake_req and dwell expiry.
- Simultaneous events:
  - sleep_req and wake_req both high in ON: sleep_req is taken.
  - Both high in SLEEP: wake_req is taken.
  - Requests arriving during transitional states are ignored; they must still be high when ON or SLEEP is reached to take effect.

Test Plan:
- Power-up (SYNC=2, DEBOUNCE=16, STEP=4): deassert rst, then set pg_vdd=pg_vddio=1 at cycle 0.
  - pg_ok is 1 from cycle 2.
  - state=1 at cycle 18, state=2 at cycle 22.
  - ready=1 at 22; ring_ctrl=0x04.
- Debounce glitch: pg_vddio drops for 1 cycle at synced count 10 -> counter restarts and ENABLE is delayed by the full glitch offset; no pg_fault.
- Retention round trip: in ON, pulse sleep_req for 1 cycle.
  - ring_ctrl: 0x05 for 4 cycles, then 0x03 (SLEEP).
  - Then pulse wake_req: 0x05 for 4 cycles, then 0x04 with ready=1.
- Fault priority: in RET_ENTRY, drop pg_vdd -> after SYNC cycles, state=0, ring_ctrl=0x01, pg_fault=1 for exactly one cycle.
- Simultaneous requests: in ON with sleep_req=wake_req=1 -> RET_ENTRY. Hold both high into SLEEP -> RET_EXIT on the next cycle.
- Mid-sequence reset: assert rst during ENABLE -> next cycle state=0, ring_ctrl=0x01, pg_fault=0, counter=0.
